tdm_demux_8ch: RTL
==================

Name: tdm_demux_8ch

Overview:
- Receive end of the team's 8:1 time-division mux link. The transmit side scans `sel` 0..7 and serializes one sample per channel per frame, flagging channel 0 with start-of-frame.
- This block rebuilds the 8 channel samples from that stream into one registered parallel word, with valid/ready handshakes on both sides.
- It detects frame-sync errors and resynchronises on the next start-of-frame.

Parameters:
- WIDTH, 1, bits per channel sample (the 1-bit mux case is WIDTH=1).

Ports:
- clk  in  1  single clock; all logic on rising edge.
- rst  in  1  synchronous, active-high reset.
- in_valid  in  1  serial beat present.
- in_sof  in  1  beat carries channel 0 (start of frame); qualified by in_valid.
- in_data  in  WIDTH  channel sample.
- in_ready  out  1  beat accepted this cycle when in_valid && in_ready.
- out_valid  out  1  out_data holds a complete frame.
- out_ready  in  1  consumer takes frame when out_valid && out_ready.
- out_data  out  8*WIDTH  channel k at bits [k*WIDTH +: WIDTH]; channel 0 at the LSBs.
- cur_chan  out  3  next channel slot expected (0..7).
- sync_err  out  1  one-cycle pulse on a frame-sync violation.

Behaviour:
- Reset (rst=1 at an edge):
  - state=HUNT, cur_chan=0, out_valid=0, out_data=0, sync_err=0, assembly register=0.
  - A reset mid-frame discards the partial frame and any pending output word.
- in_ready:
  - in_ready = !(state==RUN && cur_chan==7 && out_valid && !out_ready).
  - This stalls only the completing beat, and only when the output register is full and not draining.
  - It is combinational from state and out_ready; no path from in_valid.
- State HUNT:
  - Accepted beat with in_sof=1: store into slot 0, cur_chan=1, go to RUN.
  - Accepted beat with in_sof=0: dropped, no error pulse.
  - in_ready=1 in HUNT.
- State RUN, accepted beat, cur_chan==0:
  - in_sof=1: store slot 0, cur_chan=1.
  - in_sof=0: beat dropped, sync_err=1 for 1 cycle, go to HUNT, cur_chan=0.
- State RUN, accepted beat, cur_chan in 1..7:
  - in_sof=0: store slot cur_chan and increment cur_chan. 7 wraps to 0.
  - in_sof=1: sync_err=1 for 1 cycle. The partial frame is discarded. The beat becomes slot 0 of a new frame and cur_chan=1. No output is produced.
- Frame completion:
  - Trigger: accepted beat at cur_chan==7 with in_sof=0.
  - Effect: on the same edge, out_data is loaded with slots 0..6 plus this beat, and out_valid=1.
  - Latency: out_valid is visible the cycle after the channel-7 beat is accepted.
- Output register:
  - out_data is stable while out_valid && !out_ready.
  - If out_valid && out_ready with no completion that cycle, out_valid goes to 0. out_data is retained and is don't-care.
  - If a drain and a completion happen in the same cycle, out_valid stays 1 and out_data takes the new frame, giving full throughput of 1 frame per 8 beats with no bubble.
- No beat is ever silently overwritten:
  - Beats are only discarded by the HUNT and sync-error rules.
  - Beats held off by in_ready=0 are the sender's responsibility to hold stable.
- sync_err is registered, high exactly 1 cycle per violation.

Test Plan:
- Basic frame:
  - Stimulus: WIDTH=4, reset, then 8 back-to-back beats, sof on the first, data 0x1..0x8, out_ready=1.
  - Required: out_valid=1 one cycle after beat 8; out_data=0x87654321; cur_chan returns to 0; sync_err never high.
- Back-to-back frames:
  - Stimulus: continuous frames with out_ready=1.
  - Required: out_valid high for 1 cycle every 8 cycles, each word correct, in_ready constantly 1.
- Backpressure:
  - Stimulus: out_ready=0 after frame 1 completes; send frame 2.
  - Required: in_ready=0 with frame 2 channel 7 presented and cur_chan=7; out_data holds frame 1. Raising out_ready loads frame 2 on the same edge, and out_valid stays 1.
- Early sof:
  - Stimulus: sof at cur_chan=5.
  - Required: sync_err pulse; cur_chan=1; the next 7 beats complete a frame whose slot 0 is the early-sof beat.
- Missing sof:
  - Stimulus: in RUN at cur_chan=0, a beat with sof=0, then 3 beats without sof, then a valid frame.
  - Required: one sync_err pulse; those 4 beats dropped; the following sof frame is output correctly.
- Reset mid-frame:
  - Stimulus: rst high for 1 cycle after 4 beats, with a pending out_valid.
  - Required: out_valid=0, out_data=0, cur_chan=0, state HUNT; a subsequent non-sof beat is dropped.

Source files
------------

// File: rtl/tdm_demux_8ch.sv
// Receive side of the 8:1 TDM link: rebuilds one frame of 8 channel samples
// into a registered parallel word, with frame-sync checking and resync.
module tdm_demux_8ch #(
    parameter int WIDTH = 1
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               in_valid,
    input  logic               in_sof,
    input  logic [WIDTH-1:0]   in_data,
    output logic               in_ready,
    output logic               out_valid,
    input  logic               out_ready,
    output logic [8*WIDTH-1:0] out_data,
    output logic [2:0]         cur_chan,
    output logic               sync_err
);

    typedef enum logic {
        HUNT,
        RUN
    } state_t;

    state_t               state;
    logic [8*WIDTH-1:0]   asm_q;
    logic                 acc;

    // Only the frame-completing beat can stall, and only behind a full output.
    assign in_ready = !(state == RUN && cur_chan == 3'd7 &&
                        out_valid && !out_ready);
    assign acc      = in_valid && in_ready;

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= HUNT;
            cur_chan  <= 3'd0;
            out_valid <= 1'b0;
            out_data  <= '0;
            sync_err  <= 1'b0;
            asm_q     <= '0;
        end else begin
            sync_err <= 1'b0;
            if (out_valid && out_ready) begin
                out_valid <= 1'b0;
            end
            if (acc) begin
                unique case (state)
                    HUNT: begin
                        if (in_sof) begin
                            asm_q[WIDTH-1:0] <= in_data;
                            cur_chan         <= 3'd1;
                            state            <= RUN;
                        end
                    end
                    RUN: begin
                        if (cur_chan == 3'd0) begin
                            if (in_sof) begin
                                asm_q[WIDTH-1:0] <= in_data;
                                cur_chan         <= 3'd1;
                            end else begin
                                sync_err <= 1'b1;
                                state    <= HUNT;
                            end
                        end else if (in_sof) begin
                            // Early sof: restart the frame on this beat.
                            sync_err         <= 1'b1;
                            asm_q[WIDTH-1:0] <= in_data;
                            cur_chan         <= 3'd1;
                        end else begin
                            asm_q[cur_chan*WIDTH +: WIDTH] <= in_data;
                            cur_chan <= cur_chan + 3'd1;
                            if (cur_chan == 3'd7) begin
                                out_data  <= {in_data, asm_q[7*WIDTH-1:0]};
                                out_valid <= 1'b1;
                            end
                        end
                    end
                    default: state <= HUNT;
                endcase
            end
        end
    end

endmodule
